// File: rtl/compensation_weight_scanner_if.sv
// Bundle of signals between the weight-tile scanner, the weight SRAM read port,
// the layer controller (start) and the compensation memory downstream.
//
// Protocol (no back-pressure anywhere on this bundle):
//   - start: single-cycle request from the controller. The scanner accepts it
//     only in IDLE or DONE and ignores it while busy.
//   - w_ren/w_addr -> w_rdata: fixed one-cycle SRAM read latency. The word for
//     an address presented with w_ren=1 in cycle N is valid on w_rdata in N+1.
//   - Compensation_out_valid: one-cycle pulse that qualifies Compensation_Weight.
//     The downstream memory must accept it. Compensation_Weight holds its last
//     value while valid is low.
//   - change_col: one-cycle pulse that advances the downstream index to the next
//     column base. It can coincide with Compensation_out_valid.
//   - load_weight_done: level. It is held from the end of a scan until the
//     next accepted start.
interface compensation_weight_scanner_if;
    logic       start;
    logic       w_ren;
    logic [5:0] w_addr;
    logic [7:0] w_rdata;
    logic [2:0] Compensation_Weight;
    logic       Compensation_out_valid;
    logic       change_col;
    logic       load_weight_done;
    logic       comp_overflow;
    logic       busy;

    // Controller / SRAM / compensation-memory side.
    modport master (
        output start,
        input  w_ren,
        input  w_addr,
        output w_rdata,
        input  Compensation_Weight,
        input  Compensation_out_valid,
        input  change_col,
        input  load_weight_done,
        input  comp_overflow,
        input  busy
    );

    // Scanner side.
    modport slave (
        input  start,
        output w_ren,
        output w_addr,
        input  w_rdata,
        output Compensation_Weight,
        output Compensation_out_valid,
        output change_col,
        output load_weight_done,
        output comp_overflow,
        output busy
    );
endinterface

// File: rtl/compensation_weight_scanner.sv
// Scans the 8x8 signed weight tile column by column. Each weight that does not
// fit the low-cost PE's LOW_BITS signed datapath produces its row index as a
// compensation weight. Each column holds at most 3 such entries; any further
// outliers in that column are dropped and raise the sticky comp_overflow.
//
// Pipeline for address k, where start is sampled in cycle T:
//   T+1+k  w_ren/w_addr registered out
//   T+2+k  w_rdata valid, row/col of the same address held in the evaluate stage
//   T+3+k  valid / change_col registered out
// DRAIN is held until the result for address 63 has been presented. As a
// result, load_weight_done rises strictly after the last change_col.
module compensation_weight_scanner #(
    parameter int LOW_BITS = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    compensation_weight_scanner_if.slave bus,
    output logic [1:0]                   dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Signed range handled natively by the reduced PE datapath.
    localparam int LOW_MIN = -(1 <<< (LOW_BITS - 1));
    localparam int LOW_MAX = (1 <<< (LOW_BITS - 1)) - 1;

    state_e     state_q, state_d;

    // Read-issue stage.
    logic       ren_q, ren_d;
    logic [5:0] addr_q, addr_d;

    // Evaluate stage. It travels alongside the SRAM read latency.
    logic       ev_vld_q;
    logic [5:0] ev_addr_q;

    // Per-column entry counter (0..3).
    logic [1:0] cnt_q, cnt_d;

    // Registered outputs.
    logic [2:0] cw_q;
    logic       valid_q;
    logic       chg_q;
    logic       ovf_q;
    logic       last_q;

    // Evaluate-stage combinational results.
    logic [2:0] row;
    logic [1:0] cnt_cur;
    int         rdata_s;
    logic       outlier;
    logic       emit;
    logic       drop;
    logic       col_end;
    logic       start_ok;

    // A start is honoured only when no scan is in flight.
    assign start_ok = bus.start && ((state_q == IDLE) || (state_q == DONE));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and read-address generation.
    always_comb begin
        state_d = state_q;
        ren_d   = 1'b0;
        addr_d  = 6'd0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = READ;
                end
            end
            READ: begin
                if (addr_q == 6'd63) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Leave only once the last column's result is on the outputs.
                if (last_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    state_d = READ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == READ) begin
            ren_d  = 1'b1;
            addr_d = (state_q == READ) ? addr_q + 6'd1 : 6'd0;
        end
    end

    // Read-issue registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ren_q  <= 1'b0;
            addr_q <= 6'd0;
        end else begin
            ren_q  <= ren_d;
            addr_q <= addr_d;
        end
    end

    // Evaluate stage. It captures the address whose data arrives next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ev_vld_q  <= 1'b0;
            ev_addr_q <= 6'd0;
        end else begin
            ev_vld_q  <= ren_q;
            ev_addr_q <= addr_q;
        end
    end

    assign rdata_s = int'($signed(bus.w_rdata));

    // Outlier test and per-column slot accounting.
    always_comb begin
        row     = ev_addr_q[2:0];
        // Row 0 opens a new column, so count from zero there.
        cnt_cur = (row == 3'd0) ? 2'd0 : cnt_q;
        outlier = (rdata_s < LOW_MIN) || (rdata_s > LOW_MAX);
        emit    = ev_vld_q && outlier && (cnt_cur != 2'd3);
        drop    = ev_vld_q && outlier && (cnt_cur == 2'd3);
        // A full column has already moved the downstream index to the next base.
        col_end = ev_vld_q && (row == 3'd7) && (cnt_cur != 2'd3);
        cnt_d   = cnt_q;
        if (ev_vld_q) begin
            cnt_d = emit ? cnt_cur + 2'd1 : cnt_cur;
        end
    end

    // Column counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Output registers. Compensation_Weight holds between pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cw_q    <= 3'd0;
            valid_q <= 1'b0;
            chg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= emit;
            chg_q   <= col_end;
            last_q  <= ev_vld_q && (ev_addr_q == 6'd63);
            if (emit) begin
                cw_q <= row;
            end
            if (start_ok) begin
                ovf_q <= 1'b0;
            end else if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign bus.w_ren                  = ren_q;
    assign bus.w_addr                 = addr_q;
    assign bus.Compensation_Weight    = cw_q;
    assign bus.Compensation_out_valid = valid_q;
    assign bus.change_col             = chg_q;
    assign bus.comp_overflow          = ovf_q;
    assign bus.busy                   = (state_q == READ) || (state_q == DRAIN);
    assign bus.load_weight_done       = (state_q == DONE);
    assign dbg_state_o                = state_q;

endmodule

// File: tb/tb_compensation_weight_scanner.sv
// Bench for compensation_weight_scanner. The SRAM is modelled with a one-cycle
// read latency. A reference model derives, from the tile contents alone, which
// cycle offsets after start should show valid/change_col/overflow.
module tb_compensation_weight_scanner;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;

    compensation_weight_scanner_if bus ();

    compensation_weight_scanner #(.LOW_BITS(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    logic signed [7:0] mem [64];

    always @(posedge clk) begin
        if (bus.w_ren) bus.w_rdata <= mem[bus.w_addr];
    end

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0] last_cw = 3'd0;
    bit         exp_v   [80];
    logic [2:0] exp_cw  [80];
    bit         exp_c   [80];
    bit         exp_drop[80];
    bit         exp_ovf [80];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_outlier(input logic signed [7:0] w);
        return (w < -16) || (w > 15);
    endfunction

    // From the tile alone, work out at which offsets after start each event is due.
    task automatic build_model();
        bit ovf;
        for (int i = 0; i < 80; i++) begin
            exp_v[i] = 0; exp_cw[i] = 3'd0; exp_c[i] = 0; exp_drop[i] = 0; exp_ovf[i] = 0;
        end
        for (int col = 0; col < 8; col++) begin
            int cnt;
            cnt = 0;
            for (int row = 0; row < 8; row++) begin
                int off;
                off = col * 8 + row + 3;
                if (row == 7) exp_c[off] = (cnt < 3);
                if (is_outlier(mem[col * 8 + row])) begin
                    if (cnt < 3) begin
                        exp_v[off]  = 1;
                        exp_cw[off] = 3'(row);
                        cnt++;
                    end else begin
                        exp_drop[off] = 1;
                    end
                end
            end
        end
        ovf = 0;
        for (int k = 0; k < 80; k++) begin
            ovf = ovf | exp_drop[k];
            exp_ovf[k] = ovf;
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_valid"}, bus.Compensation_out_valid, 0);
        check({tag, "_chg"},   bus.change_col, 0);
        check({tag, "_busy"},  bus.busy, 0);
        check({tag, "_wren"},  bus.w_ren, 0);
    endtask

    // Run one scan, checking every output on every cycle T+1..T+69.
    // When rst_at is nonzero, reset is pulsed during cycle T+rst_at.
    task automatic run_scan(input int rst_at, input bit poke_start);
        build_model();
        bus.start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 69; k++) begin
            @(negedge clk);
            if (k == 1) bus.start = 1'b0;
            if (poke_start && k == 30) bus.start = 1'b1;
            if (poke_start && k == 31) bus.start = 1'b0;
            if (exp_v[k]) last_cw = exp_cw[k];
            check("valid",      bus.Compensation_out_valid, exp_v[k]);
            check("cw",         bus.Compensation_Weight, last_cw);
            check("change_col", bus.change_col, exp_c[k]);
            check("overflow",   bus.comp_overflow, exp_ovf[k]);
            check("busy",       bus.busy, k <= 66);
            check("done",       bus.load_weight_done, k >= 67);
            check("w_ren",      bus.w_ren, k <= 64);
            if (k <= 64) check("w_addr", bus.w_addr, k - 1);
            if (k == rst_at) begin
                #1 rst = 1'b1;
                #1;
                check_quiet("async_rst");
                check("async_rst_cw",   bus.Compensation_Weight, 0);
                check("async_rst_done", bus.load_weight_done, 0);
                check("async_rst_ovf",  bus.comp_overflow, 0);
                check("async_rst_addr", bus.w_addr, 0);
                last_cw = 3'd0;
                @(negedge clk);
                rst = 1'b0;
                break;
            end
        end
    endtask

    task automatic random_tile();
        for (int i = 0; i < 64; i++) begin
            case ($urandom_range(0, 5))
                0:       mem[i] = 8'($urandom);
                1: begin
                    case ($urandom_range(0, 3))
                        0: mem[i] = -8'sd17;
                        1: mem[i] = -8'sd16;
                        2: mem[i] = 8'sd15;
                        default: mem[i] = 8'sd16;
                    endcase
                end
                default: mem[i] = 8'($urandom_range(0, 31)) - 8'd16;
            endcase
        end
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 8'sd0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        check("reset_cw",   bus.Compensation_Weight, 0);
        check("reset_done", bus.load_weight_done, 0);
        check("reset_ovf",  bus.comp_overflow, 0);
        check("reset_addr", bus.w_addr, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_quiet("idle");

        // No outliers: only change_col pulses.
        for (int i = 0; i < 64; i++) mem[i] = 8'sd3;
        run_scan(0, 0);

        // The done level holds until the next start.
        repeat (5) begin
            @(negedge clk);
            check("done_hold", bus.load_weight_done, 1);
            check("done_busy", bus.busy, 0);
        end

        // Directed tile: boundaries, column overflow, row-7 emit with change_col.
        for (int i = 0; i < 64; i++) mem[i] = 8'sd0;
        mem[1]  = 8'sd100;  mem[6]  = 8'sd100;
        mem[8]  = -8'sd16;  mem[9]  = 8'sd15;  mem[10] = -8'sd17; mem[11] = 8'sd16;
        mem[16] = 8'sh80;   mem[18] = 8'sh80;  mem[20] = 8'sh80;  mem[21] = 8'sh80;
        mem[29] = 8'sd127;  mem[30] = 8'sd127; mem[31] = 8'sd127;
        run_scan(0, 0);

        // Random tiles. One scan also pulses start while busy.
        for (int n = 0; n < 3; n++) begin
            random_tile();
            run_scan(0, n == 1);
        end

        // Reset mid-scan, a few quiet cycles, then a full rescan.
        random_tile();
        run_scan(20, 0);
        repeat (4) begin
            @(negedge clk);
            check_quiet("post_rst");
            check("post_rst_done", bus.load_weight_done, 0);
        end
        run_scan(0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
